// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared arbiter state encoding and data memory geometry
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational two-way round-robin pick
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    // On a tie the requester that was not served last wins
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter, three cycles per access
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              R0_REQ,
  input  logic              R0_WR,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_WDATA,
  output logic              R0_GNT,
  output logic              R0_DONE,
  output logic [DATA_W-1:0] R0_RDATA,
  input  logic              R1_REQ,
  input  logic              R1_WR,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_WDATA,
  output logic              R1_GNT,
  output logic              R1_DONE,
  output logic [DATA_W-1:0] R1_RDATA,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic              M_WR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              BUSY,
  output logic              OWNER
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

  logic pick_winner;
  logic pick_valid;

  arb_rr_pick u_pick (
    .req    ({R1_REQ, R0_REQ}),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_ACCESS;
          owner_d = pick_winner;
          last_d  = pick_winner;
          wr_d    = pick_winner ? R1_WR    : R0_WR;
          addr_d  = pick_winner ? R1_ADDR  : R0_ADDR;
          wdata_d = pick_winner ? R1_WDATA : R0_WDATA;
        end
      end
      ARB_ACCESS: state_d = ARB_DONE;
      ARB_DONE: begin
        state_d = ARB_IDLE;
        owner_d = 1'b0;
        if (!wr_q) begin
          if (owner_q) hold1_d = M_RDATA;
          else         hold0_d = M_RDATA;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops
    gnt_d     = (state_d != ARB_IDLE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    done_d    = (state_d == ARB_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    m_wr_d    = (state_d == ARB_ACCESS) && wr_d;
    m_addr_d  = (state_d != ARB_IDLE) ? addr_d  : '0;
    m_wdata_d = (state_d != ARB_IDLE) ? wdata_d : '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ARB_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold0_q   <= '0;
      hold1_q   <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign R0_GNT  = gnt_q[0];
  assign R1_GNT  = gnt_q[1];
  assign R0_DONE = done_q[0];
  assign R1_DONE = done_q[1];
  assign M_WR    = m_wr_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;
  assign BUSY    = (state_q != ARB_IDLE);
  assign OWNER   = owner_q;

  // Read data is live from memory during the done cycle, then from the hold register
  assign R0_RDATA = (done_q[0] && !wr_q) ? M_RDATA : hold0_q;
  assign R1_RDATA = (done_q[1] && !wr_q) ? M_RDATA : hold1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        Clock;
  logic        Reset;
  logic        R0_REQ, R0_WR, R0_GNT, R0_DONE;
  logic [7:0]  R0_ADDR;
  logic [15:0] R0_WDATA, R0_RDATA;
  logic        R1_REQ, R1_WR, R1_GNT, R1_DONE;
  logic [7:0]  R1_ADDR;
  logic [15:0] R1_WDATA, R1_RDATA;
  logic [7:0]  M_ADDR;
  logic        M_WR;
  logic [15:0] M_WDATA, M_RDATA;
  logic        BUSY, OWNER;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:255];
  logic        mem_ready = 1'b0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .R0_REQ(R0_REQ), .R0_WR(R0_WR), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
    .R0_GNT(R0_GNT), .R0_DONE(R0_DONE), .R0_RDATA(R0_RDATA),
    .R1_REQ(R1_REQ), .R1_WR(R1_WR), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
    .R1_GNT(R1_GNT), .R1_DONE(R1_DONE), .R1_RDATA(R1_RDATA),
    .M_ADDR(M_ADDR), .M_WR(M_WR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
    .BUSY(BUSY), .OWNER(OWNER)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous-read memory; every location starts as 16'h5A00 | address
  always @(posedge Clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h5A00 | 16'(i);
      mem_ready <= 1'b1;
    end else begin
      if (M_WR) mem[M_ADDR] <= M_WDATA;
      M_RDATA <= mem[M_ADDR];
    end
  end

  task step;
    @(posedge Clock);
    #1;
  endtask

  task clear_inputs;
    R0_REQ = 0; R0_WR = 0; R0_ADDR = 0; R0_WDATA = 0;
    R1_REQ = 0; R1_WR = 0; R1_ADDR = 0; R1_WDATA = 0;
  endtask

  task do_reset;
    clear_inputs();
    Reset = 1;
    step();
    step();
    Reset = 0;
  endtask

  task test_reset;
    do_reset();
    checks++; if ({R0_GNT, R1_GNT, R0_DONE, R1_DONE} !== 4'b0) begin failures++; $display("FAIL rst_gnt_done got=%b exp=0000", {R0_GNT, R1_GNT, R0_DONE, R1_DONE}); end
    checks++; if (M_WR !== 1'b0) begin failures++; $display("FAIL rst_mwr got=%b exp=0", M_WR); end
    checks++; if ({M_ADDR, M_WDATA} !== 24'h0) begin failures++; $display("FAIL rst_mbus got=%h exp=0", {M_ADDR, M_WDATA}); end
    checks++; if ({BUSY, OWNER} !== 2'b00) begin failures++; $display("FAIL rst_busy_owner got=%b exp=00", {BUSY, OWNER}); end
    checks++; if ({R0_RDATA, R1_RDATA} !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {R0_RDATA, R1_RDATA}); end
  endtask

  task test_write_r0;
    R0_REQ = 1; R0_WR = 1; R0_ADDR = 8'h10; R0_WDATA = 16'hBEEF;
    step();
    checks++; if ({R0_GNT, R1_GNT, R0_DONE} !== 3'b100) begin failures++; $display("FAIL wr_access_gnt got=%b exp=100", {R0_GNT, R1_GNT, R0_DONE}); end
    checks++; if (M_WR !== 1'b1) begin failures++; $display("FAIL wr_access_mwr got=%b exp=1", M_WR); end
    checks++; if (M_ADDR !== 8'h10) begin failures++; $display("FAIL wr_access_addr got=%h exp=10", M_ADDR); end
    checks++; if (M_WDATA !== 16'hBEEF) begin failures++; $display("FAIL wr_access_wdata got=%h exp=beef", M_WDATA); end
    checks++; if ({BUSY, OWNER} !== 2'b10) begin failures++; $display("FAIL wr_access_busy got=%b exp=10", {BUSY, OWNER}); end
    step();
    checks++; if ({R0_GNT, R0_DONE, R1_GNT, R1_DONE} !== 4'b1100) begin failures++; $display("FAIL wr_done got=%b exp=1100", {R0_GNT, R0_DONE, R1_GNT, R1_DONE}); end
    checks++; if (M_WR !== 1'b0) begin failures++; $display("FAIL wr_done_mwr got=%b exp=0", M_WR); end
    R0_REQ = 0; R0_WR = 0;
    step();
    checks++; if ({R0_GNT, R0_DONE, BUSY, OWNER} !== 4'b0000) begin failures++; $display("FAIL wr_idle got=%b exp=0000", {R0_GNT, R0_DONE, BUSY, OWNER}); end
    checks++; if (M_ADDR !== 8'h00) begin failures++; $display("FAIL wr_idle_addr got=%h exp=00", M_ADDR); end
    checks++; if (mem[8'h10] !== 16'hBEEF) begin failures++; $display("FAIL wr_mem got=%h exp=beef", mem[8'h10]); end
  endtask

  task test_read_r1;
    R1_REQ = 1; R1_WR = 0; R1_ADDR = 8'h10;
    step();
    checks++; if ({R1_GNT, R0_GNT, M_WR, OWNER} !== 4'b1001) begin failures++; $display("FAIL rd_access got=%b exp=1001", {R1_GNT, R0_GNT, M_WR, OWNER}); end
    checks++; if (M_ADDR !== 8'h10) begin failures++; $display("FAIL rd_access_addr got=%h exp=10", M_ADDR); end
    step();
    checks++; if (R1_DONE !== 1'b1) begin failures++; $display("FAIL rd_done got=%b exp=1", R1_DONE); end
    checks++; if (R1_RDATA !== 16'hBEEF) begin failures++; $display("FAIL rd_done_data got=%h exp=beef", R1_RDATA); end
    checks++; if (R0_RDATA !== 16'h0) begin failures++; $display("FAIL rd_other_data got=%h exp=0", R0_RDATA); end
    R1_REQ = 0;
    step();
    step();
    checks++; if (R1_RDATA !== 16'hBEEF) begin failures++; $display("FAIL rd_hold got=%h exp=beef", R1_RDATA); end
    checks++; if ({R1_DONE, BUSY} !== 2'b00) begin failures++; $display("FAIL rd_idle got=%b exp=00", {R1_DONE, BUSY}); end
  endtask

  task test_tie;
    do_reset();
    R0_REQ = 1; R0_WR = 0; R0_ADDR = 8'h10;
    R1_REQ = 1; R1_WR = 0; R1_ADDR = 8'h20;
    step();
    checks++; if ({R0_GNT, R1_GNT, OWNER} !== 3'b100) begin failures++; $display("FAIL tie1_winner got=%b exp=100", {R0_GNT, R1_GNT, OWNER}); end
    step();
    checks++; if ({R0_DONE, R1_DONE} !== 2'b10) begin failures++; $display("FAIL tie1_done got=%b exp=10", {R0_DONE, R1_DONE}); end
    checks++; if (R0_RDATA !== 16'hBEEF) begin failures++; $display("FAIL tie1_data got=%h exp=beef", R0_RDATA); end
    step();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL tie_idle_busy got=%b exp=0", BUSY); end
    step();
    checks++; if ({R0_GNT, R1_GNT, OWNER} !== 3'b011) begin failures++; $display("FAIL tie2_winner got=%b exp=011", {R0_GNT, R1_GNT, OWNER}); end
    step();
    checks++; if ({R0_DONE, R1_DONE} !== 2'b01) begin failures++; $display("FAIL tie2_done got=%b exp=01", {R0_DONE, R1_DONE}); end
    checks++; if (R1_RDATA !== 16'h5A20) begin failures++; $display("FAIL tie2_data got=%h exp=5a20", R1_RDATA); end
    R0_REQ = 0; R1_REQ = 0;
    step();
    checks++; if ({BUSY, R0_RDATA} !== {1'b0, 16'hBEEF}) begin failures++; $display("FAIL tie_end got=%h exp=0beef", {BUSY, R0_RDATA}); end
  endtask

  task test_back_to_back;
    logic exp_owner;
    int   ndone;
    do_reset();
    exp_owner = 1'b0;
    ndone = 0;
    R0_REQ = 1; R0_WR = 0; R0_ADDR = 8'h40;
    R1_REQ = 1; R1_WR = 0; R1_ADDR = 8'h41;
    for (int t = 0; t < 10; t++) begin
      step();
      checks++; if ({R1_GNT, R0_GNT} !== (exp_owner ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_gnt t=%0d got=%b exp_owner=%0d", t, {R1_GNT, R0_GNT}, exp_owner); end
      checks++; if (OWNER !== exp_owner) begin failures++; $display("FAIL b2b_owner t=%0d got=%b exp=%b", t, OWNER, exp_owner); end
      step();
      if (R0_DONE | R1_DONE) ndone++;
      checks++; if ({R1_DONE, R0_DONE} !== (exp_owner ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_done t=%0d got=%b exp_owner=%0d", t, {R1_DONE, R0_DONE}, exp_owner); end
      checks++; if ((exp_owner ? R1_RDATA : R0_RDATA) !== (exp_owner ? 16'h5A41 : 16'h5A40)) begin failures++; $display("FAIL b2b_data t=%0d got=%h exp=%h", t, exp_owner ? R1_RDATA : R0_RDATA, exp_owner ? 16'h5A41 : 16'h5A40); end
      step();
      checks++; if ({R0_GNT, R1_GNT, BUSY} !== 3'b000) begin failures++; $display("FAIL b2b_idle t=%0d got=%b exp=000", t, {R0_GNT, R1_GNT, BUSY}); end
      exp_owner = ~exp_owner;
    end
    R0_REQ = 0; R1_REQ = 0;
    checks++; if (ndone !== 10) begin failures++; $display("FAIL b2b_done_count got=%0d exp=10", ndone); end
  endtask

  task test_reset_mid;
    R0_REQ = 1; R0_WR = 1; R0_ADDR = 8'h50; R0_WDATA = 16'h1111;
    step();
    checks++; if (M_WR !== 1'b1) begin failures++; $display("FAIL rmid_pre_mwr got=%b exp=1", M_WR); end
    Reset = 1; R0_REQ = 0; R0_WR = 0;
    step();
    checks++; if ({M_WR, BUSY, R0_GNT, R0_DONE} !== 4'b0000) begin failures++; $display("FAIL rmid_abort got=%b exp=0000", {M_WR, BUSY, R0_GNT, R0_DONE}); end
    checks++; if ({R0_RDATA, R1_RDATA} !== 32'h0) begin failures++; $display("FAIL rmid_hold_clear got=%h exp=0", {R0_RDATA, R1_RDATA}); end
    Reset = 0;
    step();
    checks++; if ({R0_DONE, BUSY, M_WR} !== 3'b000) begin failures++; $display("FAIL rmid_no_done got=%b exp=000", {R0_DONE, BUSY, M_WR}); end
    R0_REQ = 1; R0_WR = 1; R0_ADDR = 8'h52; R0_WDATA = 16'h2222; Reset = 1;
    step();
    checks++; if ({M_WR, BUSY} !== 2'b00) begin failures++; $display("FAIL rgrant_abort got=%b exp=00", {M_WR, BUSY}); end
    Reset = 0; R0_REQ = 0; R0_WR = 0;
    step();
    checks++; if (M_WR !== 1'b0) begin failures++; $display("FAIL rgrant_mwr got=%b exp=0", M_WR); end
    step();
    checks++; if (mem[8'h52] !== 16'h5A52) begin failures++; $display("FAIL rgrant_mem got=%h exp=5a52", mem[8'h52]); end
  endtask

  task test_addr_change;
    R0_REQ = 1; R0_WR = 0; R0_ADDR = 8'h60;
    step();
    R0_ADDR = 8'hFF;
    checks++; if (M_ADDR !== 8'h60) begin failures++; $display("FAIL achg_access_addr got=%h exp=60", M_ADDR); end
    step();
    checks++; if ({R0_DONE, M_ADDR} !== {1'b1, 8'h60}) begin failures++; $display("FAIL achg_done got=%h exp=160", {R0_DONE, M_ADDR}); end
    checks++; if (R0_RDATA !== 16'h5A60) begin failures++; $display("FAIL achg_data got=%h exp=5a60", R0_RDATA); end
    R0_REQ = 0;
    step();
    checks++; if ({R0_RDATA, M_ADDR} !== {16'h5A60, 8'h00}) begin failures++; $display("FAIL achg_hold got=%h exp=5a6000", {R0_RDATA, M_ADDR}); end
  endtask

  initial begin
    Reset = 1;
    clear_inputs();
    test_reset();
    test_write_r0();
    test_read_r1();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_addr_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
